// File: rtl/program_memory_loader.sv
// Unified 32x16 program/data memory with a host loader FSM (IDLE/CLEAR/LOAD/RUN/ERROR).
// The memory port belongs to the loader until the program is in, then to the core.
module program_memory_loader #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] core_mem_addr,
  input  logic [DATA_WIDTH-1:0] core_mem_write_data,
  input  logic                  core_mem_write,
  output logic [DATA_WIDTH-1:0] core_mem_read_data,
  output logic                  start_execution,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  r_load_ready;
  logic                  r_start_execution;
  logic                  r_load_error;
  logic                  w_accept;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_accept = (r_state == S_LOAD) && load_valid && r_load_ready;

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_ptr;
    w_mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_mem_we  = 1'b1;
        w_ptr_nxt = r_ptr + PTR_ONE;
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = S_LOAD;
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      S_LOAD: begin
        // A restart takes priority over a word offered in the same cycle.
        if (load_start) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
        end else if (w_accept) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = load_data;
          w_ptr_nxt   = r_ptr + PTR_ONE;
          w_count_nxt = r_count + CNT_ONE;
          if (load_last) begin
            w_state_nxt = S_RUN;
          end else if (r_ptr == LAST_ADDR) begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      S_RUN: begin
        if (load_start) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
        end else if (core_mem_write) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = core_mem_addr;
          w_mem_wdata = core_mem_write_data;
        end
      end
      S_ERROR: begin
        if (load_start) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_ptr             <= '0;
      r_count           <= '0;
      r_load_ready      <= 1'b0;
      r_start_execution <= 1'b0;
      r_load_error      <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_ptr             <= w_ptr_nxt;
      r_count           <= w_count_nxt;
      r_load_ready      <= (w_state_nxt == S_LOAD);
      r_start_execution <= (w_state_nxt == S_RUN);
      r_load_error      <= (w_state_nxt == S_ERROR);
    end
  end

  // NOTE: the array has no reset; contents must survive reset_n and CLEAR handles initialisation.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign core_mem_read_data = r_mem[core_mem_addr];
  assign load_ready         = r_load_ready;
  assign start_execution    = r_start_execution;
  assign load_error         = r_load_error;
  assign load_count         = r_count;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: randomized host streams and core
// accesses compared against an array-based model of the memory and load status.
module tb_program_memory_loader;

  logic        clock;
  logic        reset_n;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [4:0]  core_mem_addr;
  logic [15:0] core_mem_write_data;
  logic        core_mem_write;
  logic [15:0] core_mem_read_data;
  logic        start_execution;
  logic [5:0]  load_count;
  logic        load_error;

  program_memory_loader #(
    .DEPTH(32),
    .ADDR_WIDTH(5),
    .DATA_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .core_mem_addr(core_mem_addr),
    .core_mem_write_data(core_mem_write_data),
    .core_mem_write(core_mem_write),
    .core_mem_read_data(core_mem_read_data),
    .start_execution(start_execution),
    .load_count(load_count),
    .load_error(load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: memory image, accepted-word count and the three status flags.
  logic [15:0] ref_mem [32];
  int          ref_count;
  bit          m_loading;
  bit          m_run;
  bit          m_err;
  int          n_checks;
  int          n_fail;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses load_start, then checks the 32-cycle CLEAR and arrival in LOAD.
  task automatic enter_load(input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_checks++;
    if (start_execution !== 1'b0 || load_error !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s edge0_flags: got run=%b err=%b rdy=%b want 0 0 0",
               tag, start_execution, load_error, load_ready);
    end
    for (int e = 1; e <= 32; e++) begin
      tick();
      n_checks++;
      if (load_ready !== (e == 32)) begin
        n_fail++;
        $display("FAIL %s ready_timing edge %0d: got %b want %b", tag, e, load_ready, (e == 32));
      end
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;
    ref_count = 0;
    m_loading = 1'b1;
    m_run     = 1'b0;
    m_err     = 1'b0;
    n_checks++;
    if (load_count !== 6'd0) begin
      n_fail++;
      $display("FAIL %s count_after_clear: got %0d want 0", tag, load_count);
    end
  endtask

  // Offers one host cycle and checks the status outputs against the model.
  task automatic send_word(input string tag, input logic [15:0] d, input bit valid, input bit last);
    load_valid = valid;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 16'($urandom);
    if (valid && m_loading) begin
      ref_mem[ref_count] = d;
      ref_count++;
      if (last) begin
        m_loading = 1'b0;
        m_run     = 1'b1;
      end else if (ref_count == 32) begin
        m_loading = 1'b0;
        m_err     = 1'b1;
      end
    end
    n_checks++;
    if (load_count !== 6'(ref_count) || load_ready !== m_loading ||
        start_execution !== m_run || load_error !== m_err) begin
      n_fail++;
      $display("FAIL %s status: got cnt=%0d rdy=%b run=%b err=%b want cnt=%0d rdy=%b run=%b err=%b",
               tag, load_count, load_ready, start_execution, load_error,
               ref_count, m_loading, m_run, m_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    core_mem_addr = '0; core_mem_write_data = '0; core_mem_write = 1'b0;
    m_loading = 1'b0; m_run = 1'b0; m_err = 1'b0; ref_count = 0;
    repeat (3) tick();
    n_checks++;
    if (load_ready !== 1'b0 || start_execution !== 1'b0 || load_error !== 1'b0 || load_count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b run=%b err=%b cnt=%0d want all 0",
               load_ready, start_execution, load_error, load_count);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (load_ready !== 1'b0 || start_execution !== 1'b0 || load_count !== 6'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b run=%b cnt=%0d want 0 0 0",
               load_ready, start_execution, load_count);
    end
  endtask

  task automatic test_basic_load();
    enter_load("basic");
    send_word("basic_w0", 16'h8805, 1'b1, 1'b0);
    send_word("basic_w1", 16'h8903, 1'b1, 1'b0);
    send_word("basic_w2", 16'h3900, 1'b1, 1'b1);
    for (int a = 0; a < 32; a++) begin
      core_mem_addr = 5'(a);
      #1;
      n_checks++;
      if (core_mem_read_data !== ref_mem[a]) begin
        n_fail++;
        $display("FAIL basic_read addr %0d: got %h want %h", a, core_mem_read_data, ref_mem[a]);
      end
    end
  endtask

  task automatic test_stall();
    bit pattern [4];
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
    enter_load("stall");
    for (int i = 0; i < 4; i++) send_word("stall_fixed", 16'($urandom), pattern[i], 1'b0);
    for (int i = 0; i < 12; i++) send_word("stall_rand", 16'($urandom), bit'($urandom_range(0, 1)), 1'b0);
    send_word("stall_gap", 16'hDEAD, 1'b0, 1'b1);
    send_word("stall_last", 16'($urandom), 1'b1, 1'b1);
    for (int a = 0; a < 32; a++) begin
      core_mem_addr = 5'(a);
      #1;
      n_checks++;
      if (core_mem_read_data !== ref_mem[a]) begin
        n_fail++;
        $display("FAIL stall_read addr %0d: got %h want %h", a, core_mem_read_data, ref_mem[a]);
      end
    end
  endtask

  task automatic test_overflow();
    enter_load("ovf");
    for (int i = 1; i <= 32; i++) send_word("ovf_word", 16'(i), 1'b1, 1'b0);
    send_word("ovf_after", 16'hFFFF, 1'b1, 1'b1);
    core_mem_addr = 5'd31;
    #1;
    n_checks++;
    if (core_mem_read_data !== 16'h0020 || load_count !== 6'd32) begin
      n_fail++;
      $display("FAIL ovf_final: got mem31=%h cnt=%0d want 0020 32", core_mem_read_data, load_count);
    end
    core_mem_addr = 5'd0;
    #1;
    n_checks++;
    if (core_mem_read_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL ovf_mem0: got %h want 0001", core_mem_read_data);
    end
    enter_load("ovf_restart");
  endtask

  task automatic test_core_access();
    logic [4:0]  a;
    logic [15:0] d;
    for (int i = 0; i < 5; i++) send_word("core_prog", 16'($urandom), 1'b1, i == 4);
    core_mem_addr = 5'h1F; core_mem_write_data = 16'hBEEF; core_mem_write = 1'b1;
    tick();
    core_mem_write = 1'b0;
    if (m_run) ref_mem[31] = 16'hBEEF;
    n_checks++;
    if (core_mem_read_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL core_write_1f: got %h want beef", core_mem_read_data);
    end
    for (int i = 0; i < 16; i++) begin
      a = 5'($urandom_range(0, 30));
      d = 16'($urandom);
      core_mem_addr = a; core_mem_write_data = d; core_mem_write = 1'b1;
      tick();
      core_mem_write = 1'b0;
      ref_mem[a] = d;
      n_checks++;
      if (core_mem_read_data !== ref_mem[a] || start_execution !== 1'b1) begin
        n_fail++;
        $display("FAIL core_rand addr %0d: got %h run=%b want %h run=1", a, core_mem_read_data, start_execution, ref_mem[a]);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (start_execution !== 1'b0) begin
      n_fail++;
      $display("FAIL core_async_reset: run got %b want 0", start_execution);
    end
    m_run = 1'b0; m_loading = 1'b0; m_err = 1'b0; ref_count = 0;
    tick();
    reset_n = 1'b1;
    tick();
    core_mem_addr = 5'h1F; core_mem_write_data = 16'h1234; core_mem_write = 1'b1;
    tick();
    core_mem_write = 1'b0;
    n_checks++;
    if (core_mem_read_data !== ref_mem[31]) begin
      n_fail++;
      $display("FAIL idle_write_dropped: got %h want %h", core_mem_read_data, ref_mem[31]);
    end
  endtask

  task automatic test_reload();
    enter_load("reload_prep");
    for (int i = 0; i < 6; i++) send_word("reload_prog", 16'($urandom) | 16'h0001, 1'b1, i == 5);
    enter_load("reload_run");
    for (int a = 0; a < 32; a++) begin
      core_mem_addr = 5'(a);
      #1;
      n_checks++;
      if (core_mem_read_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reload_cleared addr %0d: got %h want 0000", a, core_mem_read_data);
      end
    end
  endtask

  task automatic test_async_reset();
    send_word("areset_w0", 16'($urandom), 1'b1, 1'b0);
    send_word("areset_w1", 16'($urandom), 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (load_ready !== 1'b0 || load_count !== 6'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got rdy=%b cnt=%0d want 0 0", load_ready, load_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      core_mem_addr = 5'(a);
      #1;
      n_checks++;
      if (core_mem_read_data !== ref_mem[a]) begin
        n_fail++;
        $display("FAIL areset_retained addr %0d: got %h want %h", a, core_mem_read_data, ref_mem[a]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_load();
    test_stall();
    test_overflow();
    test_core_access();
    test_reload();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
